traffic_controller_main: RTL and testbench



---
 rtl/traffic_pkg.sv | 47 ++++
 rtl/one_hz_divider.sv | 48 ++++
 rtl/traffic_controller_main.sv | 152 +++++++++++++++
 tb/tb_traffic_controller_main.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg
// Shared definitions for the traffic-light controller: the light phases,
// the lamp pattern shown in each phase, the parameter-selector codes and
// the default phase durations (seconds).
package traffic_pkg;

    typedef enum logic [2:0] {
        PH_MG1  = 3'd0,   // main green, base part
        PH_MG2  = 3'd1,   // main green, shortened when a side car waits
        PH_MY   = 3'd2,   // main yellow
        PH_WALK = 3'd3,   // all vehicles red, walk lamp lit
        PH_SG   = 3'd4,   // side green
        PH_SGX  = 3'd5,   // side green extension
        PH_SY   = 3'd6    // side yellow
    } phase_e;

    // LEDs bit order: [6] main R, [5] main Y, [4] main G,
    //                 [3] side R, [2] side Y, [1] side G, [0] walk
    localparam logic [6:0] LED_MAIN_GREEN  = 7'h18;
    localparam logic [6:0] LED_MAIN_YELLOW = 7'h28;
    localparam logic [6:0] LED_WALK        = 7'h49;
    localparam logic [6:0] LED_SIDE_GREEN  = 7'h42;
    localparam logic [6:0] LED_SIDE_YELLOW = 7'h44;

    localparam logic [1:0] SEL_BASE = 2'b00;
    localparam logic [1:0] SEL_EXT  = 2'b01;
    localparam logic [1:0] SEL_YEL  = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    localparam int T_BASE_DEFAULT = 6;
    localparam int T_EXT_DEFAULT  = 3;
    localparam int T_YEL_DEFAULT  = 2;

    function automatic logic [6:0] phase_leds(input phase_e ph);
        logic [6:0] leds;
        case (ph)
            PH_MG1, PH_MG2: leds = LED_MAIN_GREEN;
            PH_MY:          leds = LED_MAIN_YELLOW;
            PH_WALK:        leds = LED_WALK;
            PH_SG, PH_SGX:  leds = LED_SIDE_GREEN;
            PH_SY:          leds = LED_SIDE_YELLOW;
            default:        leds = LED_MAIN_GREEN;
        endcase
        return leds;
    endfunction

endpackage

// File: rtl/one_hz_divider.sv
// one_hz_divider
// Derives a 50 % duty 1 Hz square wave and a one-cycle tick per second
// from the system clock.
// Ports:
//   clk       in  system clock
//   Reset     in  asynchronous active-high reset
//   oneHz_clk out 1 Hz square wave, low after reset
//   tick      out one-clk pulse, once every DIVIDE clk cycles
module one_hz_divider #(
    parameter int DIVIDE = 100_000
) (
    input  logic clk,
    input  logic Reset,
    output logic oneHz_clk,
    output logic tick
);

    localparam int HALF = DIVIDE / 2;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          hz_q, hz_d;
    logic          wrap;

    assign wrap = (cnt_q == CW'(HALF - 1));

    always_comb begin
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        hz_d  = wrap ? ~hz_q : hz_q;
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
            hz_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            hz_q  <= hz_d;
        end
    end

    assign oneHz_clk = hz_q;
    // The tick is taken on the wrap that completes a full square-wave
    // period, so the first one lands a whole second (DIVIDE cycles) after
    // reset release and the phase timing counts whole seconds.
    assign tick = wrap & hz_q;

endmodule

// File: rtl/traffic_controller_main.sv
// traffic_controller_main
// Traffic-light controller for a main street, a side street and a
// pedestrian crossing. Phases advance on a 1 Hz tick; durations come from
// three run-time programmable registers (tBASE, tEXT, tYEL).
// Ports:
//   clk                     in  system clock
//   Reset                   in  asynchronous active-high reset
//   Sensor                  in  side-street vehicle present (may be a short pulse)
//   Walk_Request            in  pedestrian button (may be a short pulse)
//   Reprogram               in  level; loads Time_Value into the selected parameter
//   Time_Parameter_Selector in  00 tBASE, 01 tEXT, 10 tYEL, 11 none
//   Time_Value              in  new duration in seconds (1..15)
//   oneHz_clk               out 1 Hz square wave
//   LEDs                    out lamp drive, see traffic_pkg for bit order
module traffic_controller_main
    import traffic_pkg::*;
#(
    parameter int DIVIDE     = 100_000,
    parameter int T_BASE_DEF = T_BASE_DEFAULT,
    parameter int T_EXT_DEF  = T_EXT_DEFAULT,
    parameter int T_YEL_DEF  = T_YEL_DEFAULT
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Sensor,
    input  logic       Walk_Request,
    input  logic       Reprogram,
    input  logic [1:0] Time_Parameter_Selector,
    input  logic [3:0] Time_Value,
    output logic       oneHz_clk,
    output logic [6:0] LEDs
);

    logic       tick;

    logic [3:0] t_base_q, t_base_d;
    logic [3:0] t_ext_q,  t_ext_d;
    logic [3:0] t_yel_q,  t_yel_d;
    logic       sensor_req_q, sensor_req_d;
    logic       walk_req_q,   walk_req_d;
    phase_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [6:0] leds_q;

    logic       reprog;
    logic [3:0] dur;
    logic       phase_done;

    one_hz_divider #(
        .DIVIDE(DIVIDE)
    ) u_div (
        .clk      (clk),
        .Reset    (Reset),
        .oneHz_clk(oneHz_clk),
        .tick     (tick)
    );

    assign reprog = Reprogram && (Time_Parameter_Selector != SEL_NONE)
                    && (Time_Value != 4'd0);

    // Parameter registers: rewritten every cycle while a valid reprogram is held.
    always_comb begin
        t_base_d = t_base_q;
        t_ext_d  = t_ext_q;
        t_yel_d  = t_yel_q;
        if (reprog) begin
            case (Time_Parameter_Selector)
                SEL_BASE: t_base_d = Time_Value;
                SEL_EXT:  t_ext_d  = Time_Value;
                SEL_YEL:  t_yel_d  = Time_Value;
                default:  ;
            endcase
        end
    end

    // Duration of the current phase in ticks.
    always_comb begin
        case (state_q)
            PH_MG1:  dur = t_base_q;
            PH_MG2:  dur = sensor_req_q ? t_ext_q : t_base_q;
            PH_MY:   dur = t_yel_q;
            PH_WALK: dur = t_ext_q;
            PH_SG:   dur = t_base_q;
            PH_SGX:  dur = t_ext_q;
            PH_SY:   dur = t_yel_q;
            default: dur = t_base_q;
        endcase
    end

    // ">=" rather than "==" so a phase whose duration shrinks while it is
    // running (MG2 when a side car shows up late) still ends on the next tick.
    assign phase_done = tick && (cnt_q >= (dur - 4'd1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (reprog) begin
            state_d = PH_MG1;
            cnt_d   = 4'd0;
        end else if (phase_done) begin
            cnt_d = 4'd0;
            case (state_q)
                PH_MG1:  state_d = PH_MG2;
                PH_MG2:  state_d = PH_MY;
                PH_MY:   state_d = walk_req_q ? PH_WALK : PH_SG;
                PH_WALK: state_d = PH_SG;
                PH_SG:   state_d = Sensor ? PH_SGX : PH_SY;
                PH_SGX:  state_d = PH_SY;
                PH_SY:   state_d = PH_MG1;
                default: state_d = PH_MG1;
            endcase
        end else if (tick) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // A request arriving together with its clearing event wins, so it is
    // never lost.
    always_comb begin
        sensor_req_d = Sensor
                       | (sensor_req_q & ~((state_d == PH_SG) && (state_q != PH_SG)));
        walk_req_d   = Walk_Request
                       | (walk_req_q & ~((state_q == PH_WALK) && (state_d != PH_WALK)));
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            t_base_q     <= 4'(T_BASE_DEF);
            t_ext_q      <= 4'(T_EXT_DEF);
            t_yel_q      <= 4'(T_YEL_DEF);
            sensor_req_q <= 1'b0;
            walk_req_q   <= 1'b0;
            state_q      <= PH_MG1;
            cnt_q        <= 4'd0;
            leds_q       <= LED_MAIN_GREEN;
        end else begin
            t_base_q     <= t_base_d;
            t_ext_q      <= t_ext_d;
            t_yel_q      <= t_yel_d;
            sensor_req_q <= sensor_req_d;
            walk_req_q   <= walk_req_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            // Lamp register loads together with the state, so it always
            // matches state_q without an extra cycle of latency.
            leds_q       <= phase_leds(state_d);
        end
    end

    assign LEDs = leds_q;

endmodule

// File: tb/tb_traffic_controller_main.sv
`timescale 1ns/1ps
module tb_traffic_controller_main;

    localparam int DIV = 10;   // clk cycles per simulated second

    logic       clk;
    logic       Reset;
    logic       Sensor;
    logic       Walk_Request;
    logic       Reprogram;
    logic [1:0] Time_Parameter_Selector;
    logic [3:0] Time_Value;
    logic       oneHz_clk;
    logic [6:0] LEDs;

    int n_checks;
    int n_fail;

    traffic_controller_main #(
        .DIVIDE(DIV)
    ) dut (
        .clk                    (clk),
        .Reset                  (Reset),
        .Sensor                 (Sensor),
        .Walk_Request           (Walk_Request),
        .Reprogram              (Reprogram),
        .Time_Parameter_Selector(Time_Parameter_Selector),
        .Time_Value             (Time_Value),
        .oneHz_clk              (oneHz_clk),
        .LEDs                   (LEDs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Entered at the negedge right after the phase began. Checks the first
    // and last cycle of the phase and returns at the negedge after the
    // phase has ended. Optional 3-cycle Sensor / Walk pulses at phase start.
    task automatic run_phase(input string tag, input logic [6:0] exp, input int secs,
                             input bit sp, input bit wp);
        check({tag, "_start"}, {25'd0, LEDs}, {25'd0, exp});
        if (sp) Sensor = 1'b1;
        if (wp) Walk_Request = 1'b1;
        repeat (3) @(negedge clk);
        if (sp) Sensor = 1'b0;
        if (wp) Walk_Request = 1'b0;
        repeat (secs * DIV - 4) @(negedge clk);
        check({tag, "_end"}, {25'd0, LEDs}, {25'd0, exp});
        @(negedge clk);
    endtask

    task automatic default_cycle(input string p);
        run_phase({p, "MG1"}, 7'h18, 6, 0, 0);
        run_phase({p, "MG2"}, 7'h18, 6, 0, 0);
        run_phase({p, "MY"},  7'h28, 2, 0, 0);
        run_phase({p, "SG"},  7'h42, 6, 0, 0);
        run_phase({p, "SY"},  7'h44, 2, 0, 0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        Reset = 1'b1;
        Sensor = 1'b0;
        Walk_Request = 1'b0;
        Reprogram = 1'b0;
        Time_Parameter_Selector = 2'b00;
        Time_Value = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_leds", {25'd0, LEDs}, 32'h18);
        check("rst_hz", {31'd0, oneHz_clk}, 32'd0);
        Reset = 1'b0;

        // Idle cycle; sensor pulse during SY.
        run_phase("A_MG1", 7'h18, 6, 0, 0);
        run_phase("A_MG2", 7'h18, 6, 0, 0);
        run_phase("A_MY",  7'h28, 2, 0, 0);
        run_phase("A_SG",  7'h42, 6, 0, 0);
        run_phase("A_SY",  7'h44, 2, 1, 0);

        // Short MG2 from latched sensor; walk pulse during MG1.
        run_phase("B_MG1",  7'h18, 6, 0, 1);
        run_phase("B_MG2",  7'h18, 3, 0, 0);
        run_phase("B_MY",   7'h28, 2, 0, 0);
        run_phase("B_WALK", 7'h49, 3, 0, 0);
        run_phase("B_SG",   7'h42, 6, 0, 0);
        run_phase("B_SY",   7'h44, 2, 0, 0);

        // Walk skipped; sensor held through end of SG gives SGX.
        run_phase("C_MG1", 7'h18, 6, 0, 0);
        run_phase("C_MG2", 7'h18, 6, 0, 0);
        run_phase("C_MY",  7'h28, 2, 0, 0);
        Sensor = 1'b1;
        run_phase("C_SG",  7'h42, 6, 0, 0);
        Sensor = 1'b0;
        run_phase("C_SGX", 7'h42, 3, 0, 0);
        run_phase("C_SY",  7'h44, 2, 0, 0);

        // Sensor latched during SG keeps MG2 short; reprogram tYEL=5 mid-SG.
        run_phase("D_MG1", 7'h18, 6, 0, 0);
        run_phase("D_MG2", 7'h18, 3, 0, 0);
        run_phase("D_MY",  7'h28, 2, 0, 0);
        check("D_SG_start", {25'd0, LEDs}, 32'h42);
        repeat (30) @(negedge clk);
        Reprogram = 1'b1;
        Time_Parameter_Selector = 2'b10;
        Time_Value = 4'd5;
        @(negedge clk);
        Reprogram = 1'b0;
        Time_Parameter_Selector = 2'b00;
        Time_Value = 4'd0;
        check("rp_now", {25'd0, LEDs}, 32'h18);
        // Divider keeps running: six ticks later MG1 ends.
        repeat (58) @(negedge clk);
        check("rp_MG1_end", {25'd0, LEDs}, 32'h18);
        @(negedge clk);
        run_phase("R_MG2", 7'h18, 6, 0, 0);
        run_phase("R_MY",  7'h28, 5, 0, 0);
        run_phase("R_SG",  7'h42, 6, 0, 1);
        run_phase("R_SY",  7'h44, 5, 0, 0);

        // Selector 11 and value 0 must be ignored.
        check("E_MG1_start", {25'd0, LEDs}, 32'h18);
        Reprogram = 1'b1;
        Time_Parameter_Selector = 2'b11;
        Time_Value = 4'd7;
        @(negedge clk);
        Time_Parameter_Selector = 2'b00;
        Time_Value = 4'd0;
        @(negedge clk);
        Reprogram = 1'b0;
        check("E_noeffect", {25'd0, LEDs}, 32'h18);
        repeat (57) @(negedge clk);
        check("E_MG1_end", {25'd0, LEDs}, 32'h18);
        @(negedge clk);
        run_phase("E_MG2", 7'h18, 6, 0, 0);
        run_phase("E_MY",  7'h28, 5, 0, 0);

        // Asynchronous reset in the middle of WALK.
        check("E_WALK", {25'd0, LEDs}, 32'h49);
        repeat (15) @(negedge clk);
        check("hz_pre", {31'd0, oneHz_clk}, 32'd1);
        #3 Reset = 1'b1;
        #1;
        check("arst_leds", {25'd0, LEDs}, 32'h18);
        check("arst_hz", {31'd0, oneHz_clk}, 32'd0);
        repeat (2) @(negedge clk);
        Reset = 1'b0;

        // Defaults restored (tYEL back to 2, walk latch cleared).
        default_cycle("F_");
        check("F_wrap", {25'd0, LEDs}, 32'h18);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
